rs_bm_kes_16_8: RTL and testbench
=================================

// Module: rs_bm_kes_16_8
// PURPOSE
//  Key-equation solver for the RS(16,8) decoder, GF(256), primitive poly 0x11d, t=4.
//  Sits directly downstream of the syndrome stage. Consumes the packed S0..S7 pulse and
//  runs the inversionless Berlekamp-Massey (iBM) algorithm to get error locator Lambda(x).
//  Also computes error evaluator Omega(x) = S(x)*Lambda(x) mod x^2T for Chien/Forney.
// PARAMETERS
//  T      4  correction capability; 2T syndromes, 2T iterations
//  SYM_W  8  symbol width; GF(2^8) only, 0x11d; other values unsupported
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           reset, asynchronous, active-low
//  syn_val    in   1           one-cycle pulse: syndrome bus valid
//  syndrome   in   2T*SYM_W    packed S0..S(2T-1); S0 in bits [7:0]
//  busy       out  1           high while ITER/OMEGA in progress
//  bm_val     out  1           one-cycle pulse: lambda/omega/bm_deg/bm_fail valid
//  lambda     out  (T+1)*SYM_W Lambda_0..Lambda_T, Lambda_0 in [7:0]; scaled by a nonzero constant
//  omega      out  T*SYM_W     Omega_0..Omega_(T-1), Omega_0 in [7:0]
//  bm_deg     out  4           final register length L (0..2T)
//  bm_fail    out  1           L > T: uncorrectable, valid with bm_val
//  ovf        out  1           one-cycle pulse: syndrome set dropped (pending buffer full)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, pending buffer empty, internal Lambda/B/gamma/L cleared.
//  FSM: IDLE -> ITER (r=0..2T-1, one iteration per clock) -> OMEGA (1 clock) -> IDLE,
//   or -> ITER again when the pending buffer holds a syndrome set.
//  Capture: in IDLE, syn_val at edge E0 latches the syndromes. Init: Lambda=1, B=1, L=0, gamma=1, r=0.
//   FSM enters ITER.
//  Iteration r (edges E1..E2T): delta = sum_{j=0..min(r,T)} Lambda_j*S_(r-j).
//   Lambda <= gamma*Lambda + delta*x*B  (GF add = XOR).
//   If delta!=0 and 2L<=r: B<=old Lambda, L<=r+1-L, gamma<=delta.
//   Else: B<=x*B, truncated to degree T.
//  Lambda/B registers hold T+1 coefficients. Terms above x^T are discarded.
//  Multipliers are combinational GF(256) (gf256mul_dec); no registered multiplier stages.
//  OMEGA (edge E2T+1): omega_k = sum_{j=0..k} Lambda_j*S_(k-j), k=0..T-1.
//   lambda, omega, bm_deg and bm_fail are registered and bm_val=1 for one cycle.
//  Latency: bm_val high in the cycle after edge E(2T+1), i.e. 2T+1 clocks after capture (9 for T=4).
//  busy=1 from the capture edge through the OMEGA edge. busy=0 in the bm_val cycle unless a
//   pending job starts.
//  Result outputs hold their value until the next bm_val. bm_val is never high two cycles in a row.
//  Pending buffer, one entry: syn_val while busy stores the syndromes in the buffer.
//  On the OMEGA edge, a full buffer loads into the working set and ITER restarts the same edge,
//   with no idle bubble. The buffer is then empty.
//  syn_val while busy and buffer full: new set is dropped, ovf pulses for 1 cycle,
//   and the buffer keeps its old contents.
//  syn_val on the same edge the buffer empties (OMEGA edge) is accepted into the buffer, no ovf.
//  All-zero syndromes: delta=0 every iteration -> Lambda=1, L=0, omega=0, bm_fail=0.
//  rst_n low mid-operation: immediate clear to reset state. The in-flight job and pending entry are
//   lost; no bm_val and no ovf.
// TESTING
//  1 All-zero syndromes -> bm_val 9 clks after capture; lambda=0x00_00_00_00_01, omega=0, bm_deg=0, bm_fail=0.
//  2 Single error e=0x01 at X=1 (all S_i=0x01) -> lambda={01,01,00,00,00} (L0 first), omega={01,00,00,00}, bm_deg=1.
//  3 Random 1..4 errors vs. a golden iBM model: Lambda normalised by Lambda_0 has roots at X_k^-1.
//    Omega(X^-1)/Lambda'(X^-1) gives e_k (Forney), bm_deg = number of errors, bm_fail=0.
//  4 5 random errors, or random syndromes with L>4 -> bm_fail=1 with bm_val.
//  5 Back-to-back: syn_val at E0 and E3, then a third at E5 -> second job's bm_val exactly 9 clks after
//    the first's. ovf pulse one cycle after E5; the dropped set produces no bm_val.
//  6 rst_n asserted at iteration r=4 -> all outputs 0 immediately. No bm_val follows; a new syn_val
//    after release processes normally.

Source files
------------

// File: rtl/rs_bm_kes_16_8.sv
// Key-equation solver for the RS(16,8) decoder over GF(256) (poly 0x11d), t=4.
// Runs the inversionless Berlekamp-Massey algorithm on S0..S7 to produce the
// error locator Lambda(x), then forms Omega(x) = S(x)*Lambda(x) mod x^T.
// A one-entry pending buffer lets a second syndrome set queue behind the
// running job, and that job starts on the OMEGA edge with no idle bubble.
module rs_bm_kes_16_8 #(
  parameter int T     = 4,
  parameter int SYM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     syn_val,
  input  logic [2*T*SYM_W-1:0]     syndrome,
  output logic                     busy,
  output logic                     bm_val,
  output logic [(T+1)*SYM_W-1:0]   lambda,
  output logic [T*SYM_W-1:0]       omega,
  output logic [3:0]               bm_deg,
  output logic                     bm_fail,
  output logic                     ovf
);

  localparam int NS = 2 * T;
  localparam int RW = $clog2(NS);
  localparam int LW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_OMEGA = 2'd2
  } state_e;

  // GF(256) multiply, shift-and-add reduction by x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gf256mul_dec(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      if (aa[7]) aa = {aa[6:0], 1'b0} ^ 8'h1d;
      else       aa = {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  state_e                state_q, state_d;
  logic [RW-1:0]         r_q, r_d;
  logic [NS*SYM_W-1:0]   syn_q, syn_d;
  logic [NS*SYM_W-1:0]   pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [7:0]            lam_q [0:T];
  logic [7:0]            lam_d [0:T];
  logic [7:0]            b_q   [0:T];
  logic [7:0]            b_d   [0:T];
  logic [7:0]            gamma_q, gamma_d;
  logic [LW-1:0]         l_q, l_d;

  logic                  busy_q, busy_d;
  logic                  bm_val_q, bm_val_d;
  logic [(T+1)*SYM_W-1:0] lambda_q, lambda_d;
  logic [T*SYM_W-1:0]    omega_q, omega_d;
  logic [3:0]            bm_deg_q, bm_deg_d;
  logic                  bm_fail_q, bm_fail_d;
  logic                  ovf_q, ovf_d;

  logic [7:0]            syn_s [0:NS-1];
  logic [7:0]            delta_s;
  logic [7:0]            om_s  [0:T-1];
  logic                  load_s;
  logic [NS*SYM_W-1:0]   load_src_s;

  // Unpack the working syndrome set and compute the discrepancy and Omega terms
  always_comb begin
    for (int i = 0; i < NS; i++) syn_s[i] = syn_q[i*SYM_W +: SYM_W];
    delta_s = 8'h00;
    for (int j = 0; j <= T; j++) begin
      if (RW'(j) <= r_q) delta_s = delta_s ^ gf256mul_dec(lam_q[j], syn_s[r_q - RW'(j)]);
      else               delta_s = delta_s;
    end
    for (int k = 0; k < T; k++) begin
      om_s[k] = 8'h00;
      for (int j = 0; j <= k; j++) om_s[k] = om_s[k] ^ gf256mul_dec(lam_q[j], syn_s[k-j]);
    end
  end

  // Next-state, iBM update, pending-buffer control and result registers
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    syn_d      = syn_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    lam_d      = lam_q;
    b_d        = b_q;
    gamma_d    = gamma_q;
    l_d        = l_q;
    bm_val_d   = 1'b0;
    ovf_d      = 1'b0;
    lambda_d   = lambda_q;
    omega_d    = omega_q;
    bm_deg_d   = bm_deg_q;
    bm_fail_d  = bm_fail_q;
    load_s     = 1'b0;
    load_src_s = syndrome;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          // a set queued on the previous OMEGA edge starts now
          load_s     = 1'b1;
          load_src_s = pend_q;
          if (syn_val) pend_d = syndrome;
          else         pend_vld_d = 1'b0;
        end else if (syn_val) begin
          load_s     = 1'b1;
          load_src_s = syndrome;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_ITER: begin
        lam_d[0] = gf256mul_dec(gamma_q, lam_q[0]);
        for (int i = 1; i <= T; i++)
          lam_d[i] = gf256mul_dec(gamma_q, lam_q[i]) ^ gf256mul_dec(delta_s, b_q[i-1]);
        if ((delta_s != 8'h00) && ({l_q, 1'b0} <= (LW+1)'(r_q))) begin
          b_d     = lam_q;
          l_d     = LW'(r_q) + 4'd1 - l_q;
          gamma_d = delta_s;
        end else begin
          b_d[0] = 8'h00;
          for (int i = 1; i <= T; i++) b_d[i] = b_q[i-1];
        end
        if (r_q == RW'(NS-1)) state_d = ST_OMEGA;
        else                  r_d = r_q + 3'd1;
        if (syn_val) begin
          if (pend_vld_q) begin
            ovf_d = 1'b1;
          end else begin
            pend_d     = syndrome;
            pend_vld_d = 1'b1;
          end
        end else begin
          ovf_d = 1'b0;
        end
      end
      ST_OMEGA: begin
        for (int i = 0; i <= T; i++) lambda_d[i*SYM_W +: SYM_W] = lam_q[i];
        for (int k = 0; k < T; k++)  omega_d[k*SYM_W +: SYM_W]  = om_s[k];
        bm_deg_d  = l_q;
        bm_fail_d = (l_q > LW'(T));
        bm_val_d  = 1'b1;
        if (pend_vld_q) begin
          load_s     = 1'b1;
          load_src_s = pend_q;
          // the buffer empties on this edge, so a new set is accepted into it
          if (syn_val) pend_d = syndrome;
          else         pend_vld_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          if (syn_val) begin
            pend_d     = syndrome;
            pend_vld_d = 1'b1;
          end else begin
            pend_vld_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_s) begin
      syn_d   = load_src_s;
      lam_d[0] = 8'h01;
      b_d[0]   = 8'h01;
      for (int i = 1; i <= T; i++) begin
        lam_d[i] = 8'h00;
        b_d[i]   = 8'h00;
      end
      gamma_d = 8'h01;
      l_d     = 4'd0;
      r_d     = '0;
      state_d = ST_ITER;
    end else begin
      syn_d = syn_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and result registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      r_q        <= '0;
      syn_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      for (int i = 0; i <= T; i++) begin
        lam_q[i] <= 8'h00;
        b_q[i]   <= 8'h00;
      end
      gamma_q    <= 8'h00;
      l_q        <= 4'd0;
      busy_q     <= 1'b0;
      bm_val_q   <= 1'b0;
      lambda_q   <= '0;
      omega_q    <= '0;
      bm_deg_q   <= 4'd0;
      bm_fail_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      syn_q      <= syn_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      lam_q      <= lam_d;
      b_q        <= b_d;
      gamma_q    <= gamma_d;
      l_q        <= l_d;
      busy_q     <= busy_d;
      bm_val_q   <= bm_val_d;
      lambda_q   <= lambda_d;
      omega_q    <= omega_d;
      bm_deg_q   <= bm_deg_d;
      bm_fail_q  <= bm_fail_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign bm_val  = bm_val_q;
  assign lambda  = lambda_q;
  assign omega   = omega_q;
  assign bm_deg  = bm_deg_q;
  assign bm_fail = bm_fail_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_rs_bm_kes_16_8.sv
// Bench for rs_bm_kes_16_8: random error patterns are turned into syndromes,
// and the solver's Lambda/Omega are checked against the error-locator product
// and the closed-form evaluator built from the known error locations/values.
module tb_rs_bm_kes_16_8;

  logic         clk;
  logic         rst_n;
  logic         syn_val;
  logic [63:0]  syndrome;
  logic         busy;
  logic         bm_val;
  logic [39:0]  lambda;
  logic [31:0]  omega;
  logic [3:0]   bm_deg;
  logic         bm_fail;
  logic         ovf;

  int n_checks;
  int n_fail;

  logic [7:0] gexp [0:509];
  int         glog [0:255];

  rs_bm_kes_16_8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .syn_val  (syn_val),
    .syndrome (syndrome),
    .busy     (busy),
    .bm_val   (bm_val),
    .lambda   (lambda),
    .omega    (omega),
    .bm_deg   (bm_deg),
    .bm_fail  (bm_fail),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[glog[a] + glog[b]];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    return gexp[(255 - glog[a]) % 255];
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i]       = 8'(x);
      gexp[i + 255] = 8'(x);
      glog[x]       = i;
      x = x << 1;
      if ((x & 32'h100) != 0) x = x ^ 32'h11d;
    end
    glog[0] = 0;
  endtask

  // Random error pattern -> syndromes S_i = sum e*X^(i+1), locator prod(1+X x),
  // evaluator sum_k e_k X_k prod_{j!=k}(1+X_j x).
  task automatic make_job(input int n, output logic [63:0] syn, output logic [39:0] p,
                          output logic [31:0] om, output logic [31:0] xs, output logic [31:0] es);
    int         pos [4];
    logic [7:0] xv [4];
    logic [7:0] ev [4];
    logic [7:0] pp [5];
    logic [7:0] q  [5];
    logic [7:0] oo [4];
    logic [7:0] s;
    int         cand;
    bit         dup;
    for (int k = 0; k < 4; k++) begin
      xv[k] = 8'h00;
      ev[k] = 8'h00;
      pos[k] = -1;
    end
    for (int k = 0; k < n; k++) begin
      do begin
        cand = $urandom_range(0, 15);
        dup = 1'b0;
        for (int m = 0; m < k; m++) if (pos[m] == cand) dup = 1'b1;
      end while (dup);
      pos[k] = cand;
      xv[k] = gexp[cand];
      ev[k] = 8'($urandom_range(1, 255));
    end
    for (int i = 0; i < 8; i++) begin
      s = 8'h00;
      for (int k = 0; k < n; k++) s = s ^ gmul(ev[k], gexp[(pos[k] * (i + 1)) % 255]);
      syn[i*8 +: 8] = s;
    end
    pp[0] = 8'h01;
    for (int i = 1; i < 5; i++) pp[i] = 8'h00;
    for (int k = 0; k < n; k++)
      for (int i = 4; i >= 1; i--) pp[i] = pp[i] ^ gmul(xv[k], pp[i-1]);
    for (int i = 0; i < 4; i++) oo[i] = 8'h00;
    for (int k = 0; k < n; k++) begin
      q[0] = gmul(ev[k], xv[k]);
      for (int i = 1; i < 5; i++) q[i] = 8'h00;
      for (int j = 0; j < n; j++)
        if (j != k)
          for (int i = 4; i >= 1; i--) q[i] = q[i] ^ gmul(xv[j], q[i-1]);
      for (int i = 0; i < 4; i++) oo[i] = oo[i] ^ q[i];
    end
    for (int i = 0; i < 5; i++) p[i*8 +: 8] = pp[i];
    for (int i = 0; i < 4; i++) begin
      om[i*8 +: 8] = oo[i];
      xs[i*8 +: 8] = xv[i];
      es[i*8 +: 8] = ev[i];
    end
  endtask

  task automatic start_job(input logic [63:0] s);
    @(negedge clk);
    syn_val  = 1'b1;
    syndrome = s;
    @(negedge clk);
    syn_val  = 1'b0;
    syndrome = 64'h0;
  endtask

  // Cycles after capture until bm_val is seen; -1 if it never arrives
  task automatic wait_bm(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bm_val) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({busy, bm_val, lambda, omega, bm_deg, bm_fail, ovf} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b val=%0b lam=%h om=%h deg=%0d fail=%0b ovf=%0b, want all 0",
               busy, bm_val, lambda, omega, bm_deg, bm_fail, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int cnt;
    start_job(64'h0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %0b want 1", busy); end
    wait_bm(cnt);
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL zero_latency: got %0d want 9", cnt); end
    n_checks++;
    if (lambda !== 40'h00_0000_0001) begin n_fail++; $display("FAIL zero_lambda: got %h want 0000000001", lambda); end
    n_checks++;
    if (omega !== 32'h0) begin n_fail++; $display("FAIL zero_omega: got %h want 0", omega); end
    n_checks++;
    if (bm_deg !== 4'd0 || bm_fail !== 1'b0) begin
      n_fail++; $display("FAIL zero_deg: got deg=%0d fail=%0b want 0/0", bm_deg, bm_fail);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_done: got %0b want 0", busy); end
    @(negedge clk);
    n_checks++;
    if (bm_val !== 1'b0) begin n_fail++; $display("FAIL zero_val_pulse: got %0b want 0", bm_val); end
  endtask

  task automatic test_single();
    int cnt;
    start_job({8{8'h01}});
    wait_bm(cnt);
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL single_latency: got %0d want 9", cnt); end
    n_checks++;
    if (lambda !== 40'h00_0000_0101) begin n_fail++; $display("FAIL single_lambda: got %h want 0000000101", lambda); end
    n_checks++;
    if (omega !== 32'h0000_0001) begin n_fail++; $display("FAIL single_omega: got %h want 00000001", omega); end
    n_checks++;
    if (bm_deg !== 4'd1 || bm_fail !== 1'b0) begin
      n_fail++; $display("FAIL single_deg: got deg=%0d fail=%0b want 1/0", bm_deg, bm_fail);
    end
  endtask

  task automatic test_random();
    logic [63:0] s;
    logic [39:0] p;
    logic [31:0] om, xs, es;
    logic [7:0]  l0, xi, num, den, ek, xp;
    int n, cnt;
    for (int it = 0; it < 12; it++) begin
      n = 1 + (it % 4);
      make_job(n, s, p, om, xs, es);
      start_job(s);
      wait_bm(cnt);
      n_checks++;
      if (cnt !== 9) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 9", it, cnt); end
      n_checks++;
      if (bm_deg !== 4'(n) || bm_fail !== 1'b0) begin
        n_fail++; $display("FAIL rand_deg[%0d]: got deg=%0d fail=%0b want %0d/0", it, bm_deg, bm_fail, n);
      end
      l0 = lambda[7:0];
      n_checks++;
      if (l0 === 8'h00) begin n_fail++; $display("FAIL rand_l0[%0d]: got 00 want nonzero", it); end
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (lambda[i*8 +: 8] !== gmul(l0, p[i*8 +: 8])) begin
          n_fail++; $display("FAIL rand_lambda[%0d][%0d]: got %h want %h", it, i, lambda[i*8 +: 8], gmul(l0, p[i*8 +: 8]));
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (omega[k*8 +: 8] !== gmul(l0, om[k*8 +: 8])) begin
          n_fail++; $display("FAIL rand_omega[%0d][%0d]: got %h want %h", it, k, omega[k*8 +: 8], gmul(l0, om[k*8 +: 8]));
        end
      end
      // Forney on the DUT's own Lambda/Omega must recover each error value
      for (int k = 0; k < n; k++) begin
        xi  = ginv(xs[k*8 +: 8]);
        num = 8'h00;
        xp  = 8'h01;
        for (int i = 0; i < 4; i++) begin
          num = num ^ gmul(omega[i*8 +: 8], xp);
          xp  = gmul(xp, xi);
        end
        den = lambda[15:8] ^ gmul(lambda[31:24], gmul(xi, xi));
        ek  = (den == 8'h00) ? 8'h00 : gmul(num, ginv(den));
        n_checks++;
        if (ek !== es[k*8 +: 8]) begin
          n_fail++; $display("FAIL rand_forney[%0d][%0d]: got %h want %h", it, k, ek, es[k*8 +: 8]);
        end
      end
    end
  endtask

  task automatic test_fail();
    logic [63:0] s;
    int cnt;
    for (int k = 4; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (i < k)       s[i*8 +: 8] = 8'h00;
        else if (i == k) s[i*8 +: 8] = 8'($urandom_range(1, 255));
        else             s[i*8 +: 8] = 8'($urandom_range(0, 255));
      end
      start_job(s);
      wait_bm(cnt);
      n_checks++;
      if (cnt !== 9) begin n_fail++; $display("FAIL fail_latency[%0d]: got %0d want 9", k, cnt); end
      n_checks++;
      if (bm_fail !== 1'b1 || bm_deg !== 4'(k + 1)) begin
        n_fail++; $display("FAIL fail_flag[%0d]: got deg=%0d fail=%0b want %0d/1", k, bm_deg, bm_fail, k + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] sa, sb, sc;
    logic [39:0] pa, pb, pc;
    logic [31:0] oa, ob, oc, xa, xb, xc, ea, eb, ec;
    int          bm_cyc [$];
    int          ovf_cyc [$];
    logic [39:0] lam_seen [$];
    logic [3:0]  deg_seen [$];
    logic [7:0]  l0;
    make_job(2, sa, pa, oa, xa, ea);
    make_job(3, sb, pb, ob, xb, eb);
    make_job(1, sc, pc, oc, xc, ec);
    @(negedge clk);
    syn_val  = 1'b1;
    syndrome = sa;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bm_val) begin
        bm_cyc.push_back(c);
        lam_seen.push_back(lambda);
        deg_seen.push_back(bm_deg);
      end
      if (ovf) ovf_cyc.push_back(c);
      syn_val  = (c == 2) || (c == 4);
      syndrome = (c == 2) ? sb : ((c == 4) ? sc : 64'h0);
    end
    n_checks++;
    if (bm_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_val_count: got %0d want 2", bm_cyc.size()); end
    n_checks++;
    if (ovf_cyc.size() !== 1) begin n_fail++; $display("FAIL b2b_ovf_count: got %0d want 1", ovf_cyc.size()); end
    if (ovf_cyc.size() >= 1) begin
      n_checks++;
      if (ovf_cyc[0] !== 5) begin n_fail++; $display("FAIL b2b_ovf_cycle: got %0d want 5", ovf_cyc[0]); end
    end
    if (bm_cyc.size() >= 2) begin
      n_checks++;
      if (bm_cyc[0] !== 9) begin n_fail++; $display("FAIL b2b_first_val: got %0d want 9", bm_cyc[0]); end
      n_checks++;
      if (bm_cyc[1] - bm_cyc[0] !== 9) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d want 9", bm_cyc[1] - bm_cyc[0]);
      end
      n_checks++;
      if (deg_seen[0] !== 4'd2 || deg_seen[1] !== 4'd3) begin
        n_fail++; $display("FAIL b2b_deg: got %0d,%0d want 2,3", deg_seen[0], deg_seen[1]);
      end
      l0 = lam_seen[0][7:0];
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (l0 === 8'h00 || lam_seen[0][i*8 +: 8] !== gmul(l0, pa[i*8 +: 8])) begin
          n_fail++; $display("FAIL b2b_lambda_a[%0d]: got %h want %h", i, lam_seen[0][i*8 +: 8], gmul(l0, pa[i*8 +: 8]));
        end
      end
      l0 = lam_seen[1][7:0];
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (l0 === 8'h00 || lam_seen[1][i*8 +: 8] !== gmul(l0, pb[i*8 +: 8])) begin
          n_fail++; $display("FAIL b2b_lambda_b[%0d]: got %h want %h", i, lam_seen[1][i*8 +: 8], gmul(l0, pb[i*8 +: 8]));
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] sa, sb;
    logic [39:0] pa, pb;
    logic [31:0] oa, ob, xa, xb, ea, eb;
    int vals, ovfs, cnt;
    make_job(2, sa, pa, oa, xa, ea);
    make_job(3, sb, pb, ob, xb, eb);
    start_job(sa);
    @(negedge clk);
    syn_val  = 1'b1;
    syndrome = sb;
    @(negedge clk);
    syn_val  = 1'b0;
    syndrome = 64'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, bm_val, lambda, omega, bm_deg, bm_fail, ovf} !== 80'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got busy=%0b val=%0b lam=%h om=%h deg=%0d fail=%0b ovf=%0b, want all 0",
               busy, bm_val, lambda, omega, bm_deg, bm_fail, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vals = 0;
    ovfs = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bm_val) vals++;
      if (ovf)    ovfs++;
    end
    n_checks++;
    if (vals !== 0 || ovfs !== 0) begin
      n_fail++; $display("FAIL midrst_quiet: got %0d bm_val, %0d ovf want 0/0", vals, ovfs);
    end
    start_job(64'h0);
    wait_bm(cnt);
    n_checks++;
    if (cnt !== 9 || lambda !== 40'h00_0000_0001) begin
      n_fail++; $display("FAIL midrst_recover: got lat=%0d lam=%h want 9/0000000001", cnt, lambda);
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    syn_val  = 1'b0;
    syndrome = 64'h0;
    n_checks = 0;
    n_fail   = 0;
    build_tables();
    test_reset();
    test_zero();
    test_single();
    test_random();
    test_fail();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
